uart_rx: RTL and testbench

//  Oversampling UART receiver: deserialises one asynchronous frame (start, DATA_FRAME bits,

---
 rtl/uart_rx_if.sv | 27 ++
 rtl/uart_rx.sv | 156 +++++++++++++++
 tb/tb_uart_rx.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// Serial line and parallel result signals between the UART receiver and its user.
// The master side drives the line; the slave side is the receiver.
interface uart_rx_if #(
    parameter int DATA_FRAME = 8
);
    logic                  i_rx;
    logic [DATA_FRAME-1:0] o_rx_data;
    logic                  o_rx_valid;
    logic                  o_frame_err;
    logic                  o_busy;

    modport master (
        output i_rx,
        input  o_rx_data,
        input  o_rx_valid,
        input  o_frame_err,
        input  o_busy
    );

    modport slave (
        input  i_rx,
        output o_rx_data,
        output o_rx_valid,
        output o_frame_err,
        output o_busy
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver with its own baud tick divider and 2-FF input synchroniser.
// Produces a parallel word with a 1-cycle valid strobe, or a 1-cycle frame-error strobe.
module uart_rx #(
    parameter int IN_CLK_HZ         = 50_000_000,
    parameter int DATA_FRAME        = 8,
    parameter int BAUD_RATE         = 115_200,
    parameter int OVERSAMPLING_MODE = 16,
    parameter int STOP_BIT          = 1,
    parameter bit LSB               = 1'b0
) (
    input  logic      i_clk,
    input  logic      i_rst,
    uart_rx_if.slave  bus
);
    localparam int DIV   = IN_CLK_HZ / (BAUD_RATE * OVERSAMPLING_MODE) - 1;
    localparam int DIV_W = (DIV > 0) ? $clog2(DIV + 1) : 1;
    localparam int CNT_W = $clog2(OVERSAMPLING_MODE);
    localparam int IDX_W = $clog2(DATA_FRAME + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                state_q, state_d;
    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_FRAME-1:0] shift_q, shift_d;
    logic [DATA_FRAME-1:0] rx_data_q, rx_data_d;
    logic                  err_q, err_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  frame_err_q, frame_err_d;
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic                  prev_q, prev_d;
    logic                  tick;
    logic                  start_edge;
    logic                  err_now;

    always_comb begin
        tick       = (div_cnt_q == DIV_W'(DIV));
        div_cnt_d  = tick ? '0 : div_cnt_q + DIV_W'(1);
        sync1_d    = bus.i_rx;
        sync2_d    = sync1_q;
        prev_d     = sync2_q;
        start_edge = !sync2_q && prev_q;

        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        err_d       = err_q;
        err_now     = err_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d = START;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(OVERSAMPLING_MODE / 2 - 1)) begin
                        cnt_d   = '0;
                        state_d = sync2_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(OVERSAMPLING_MODE - 1)) begin
                        cnt_d = '0;
                        // LSB selects whether the first bit ends up at bit 0 or at the MSB
                        if (LSB) begin
                            shift_d = {shift_q[DATA_FRAME-2:0], sync2_q};
                        end else begin
                            shift_d = {sync2_q, shift_q[DATA_FRAME-1:1]};
                        end
                        if (idx_q == IDX_W'(DATA_FRAME - 1)) begin
                            state_d = STOP;
                            idx_d   = '0;
                            err_d   = 1'b0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (cnt_q == CNT_W'(OVERSAMPLING_MODE - 1)) begin
                        cnt_d   = '0;
                        err_now = err_q | !sync2_q;
                        err_d   = err_now;
                        if (idx_q == IDX_W'(STOP_BIT - 1)) begin
                            state_d = IDLE;
                            if (err_now) begin
                                frame_err_d = 1'b1;
                            end else begin
                                rx_data_d  = shift_q;
                                rx_valid_d = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            err_q       <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            prev_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            err_q       <= err_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            prev_q      <= prev_d;
        end
    end

    assign bus.o_rx_data   = rx_data_q;
    assign bus.o_rx_valid  = rx_valid_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_busy      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: instance A is LSB-first with one stop bit,
// instance B is MSB-first with two stop bits; both run at 10 clocks per tick.
module tb_uart_rx;
    localparam int BIT = 160;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    int   valid_cnt_a, err_cnt_a, bad_a;
    int   valid_cnt_b, err_cnt_b, bad_b;
    logic [7:0] last_data_a, prev_data_a;
    logic prev_valid_a, prev_err_a, prev_valid_b, prev_err_b;
    int   base_v, base_e;

    uart_rx_if #(.DATA_FRAME(8)) bus_a ();
    uart_rx_if #(.DATA_FRAME(8)) bus_b ();

    uart_rx #(
        .IN_CLK_HZ(18_432_000), .DATA_FRAME(8), .BAUD_RATE(115_200),
        .OVERSAMPLING_MODE(16), .STOP_BIT(1), .LSB(1'b0)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus_a.slave)
    );

    uart_rx #(
        .IN_CLK_HZ(18_432_000), .DATA_FRAME(8), .BAUD_RATE(115_200),
        .OVERSAMPLING_MODE(16), .STOP_BIT(2), .LSB(1'b1)
    ) dut_b (
        .i_clk(clk),
        .i_rst(rst),
        .bus(bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters; bad_* counts overlapping or stretched strobes.
    initial begin
        valid_cnt_a = 0; err_cnt_a = 0; bad_a = 0;
        valid_cnt_b = 0; err_cnt_b = 0; bad_b = 0;
        last_data_a = 8'h00; prev_data_a = 8'h00;
        prev_valid_a = 1'b0; prev_err_a = 1'b0;
        prev_valid_b = 1'b0; prev_err_b = 1'b0;
    end

    always @(negedge clk) begin
        if (bus_a.o_rx_valid === 1'b1) begin
            valid_cnt_a++;
            prev_data_a = last_data_a;
            last_data_a = bus_a.o_rx_data;
        end
        if (bus_a.o_frame_err === 1'b1) err_cnt_a++;
        if ((bus_a.o_rx_valid === 1'b1 && bus_a.o_frame_err === 1'b1) ||
            (bus_a.o_rx_valid === 1'b1 && prev_valid_a) ||
            (bus_a.o_frame_err === 1'b1 && prev_err_a)) bad_a++;
        prev_valid_a = (bus_a.o_rx_valid === 1'b1);
        prev_err_a   = (bus_a.o_frame_err === 1'b1);

        if (bus_b.o_rx_valid === 1'b1) valid_cnt_b++;
        if (bus_b.o_frame_err === 1'b1) err_cnt_b++;
        if ((bus_b.o_rx_valid === 1'b1 && bus_b.o_frame_err === 1'b1) ||
            (bus_b.o_rx_valid === 1'b1 && prev_valid_b) ||
            (bus_b.o_frame_err === 1'b1 && prev_err_b)) bad_b++;
        prev_valid_b = (bus_b.o_rx_valid === 1'b1);
        prev_err_b   = (bus_b.o_frame_err === 1'b1);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic waitClk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input int sel, input logic val, input int clks);
        if (sel == 0) bus_a.i_rx = val;
        else          bus_b.i_rx = val;
        waitClk(clks);
    endtask

    task automatic sendFrame(input int sel, input logic [7:0] data, input logic stop1,
                             input logic stop2, input int nstop, input int bitclk);
        applyStimulus(sel, 1'b0, bitclk);
        for (int i = 0; i < 8; i++) applyStimulus(sel, data[i], bitclk);
        applyStimulus(sel, stop1, bitclk);
        if (nstop == 2) applyStimulus(sel, stop2, bitclk);
        applyStimulus(sel, 1'b1, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus_a.i_rx = 1'b1;
        bus_b.i_rx = 1'b1;
        waitClk(5);
        checkOutput("reset_data",  32'(bus_a.o_rx_data),   32'h00);
        checkOutput("reset_valid", 32'(bus_a.o_rx_valid),  32'h0);
        checkOutput("reset_err",   32'(bus_a.o_frame_err), 32'h0);
        checkOutput("reset_busy",  32'(bus_a.o_busy),      32'h0);
        rst = 1'b0;

        $display("[TB] test 1: 0xA5 LSB-first");
        waitClk(1000);
        base_v = valid_cnt_a; base_e = err_cnt_a;
        sendFrame(0, 8'hA5, 1'b1, 1'b1, 1, BIT);
        waitClk(100);
        checkOutput("t1_valid_count", 32'(valid_cnt_a - base_v), 32'd1);
        checkOutput("t1_data",        32'(bus_a.o_rx_data),      32'hA5);
        checkOutput("t1_err_count",   32'(err_cnt_a - base_e),   32'd0);

        $display("[TB] test 2: 40-clock glitch then 0x3C");
        base_v = valid_cnt_a; base_e = err_cnt_a;
        applyStimulus(0, 1'b0, 40);
        checkOutput("t2_busy_in_start", 32'(bus_a.o_busy), 32'h1);
        applyStimulus(0, 1'b1, 50);
        checkOutput("t2_busy_dropped",  32'(bus_a.o_busy), 32'h0);
        checkOutput("t2_glitch_valid",  32'(valid_cnt_a - base_v), 32'd0);
        checkOutput("t2_glitch_err",    32'(err_cnt_a - base_e),   32'd0);
        waitClk(200);
        sendFrame(0, 8'h3C, 1'b1, 1'b1, 1, BIT);
        waitClk(100);
        checkOutput("t2_valid_count", 32'(valid_cnt_a - base_v), 32'd1);
        checkOutput("t2_data",        32'(bus_a.o_rx_data),      32'h3C);

        $display("[TB] test 3: bad stop bit then 0x0F");
        base_v = valid_cnt_a; base_e = err_cnt_a;
        sendFrame(0, 8'h55, 1'b0, 1'b1, 1, BIT);
        applyStimulus(0, 1'b1, BIT);
        checkOutput("t3_err_count",   32'(err_cnt_a - base_e),   32'd1);
        checkOutput("t3_no_valid",    32'(valid_cnt_a - base_v), 32'd0);
        checkOutput("t3_data_held",   32'(bus_a.o_rx_data),      32'h3C);
        sendFrame(0, 8'h0F, 1'b1, 1'b1, 1, BIT);
        waitClk(100);
        checkOutput("t3_valid_count", 32'(valid_cnt_a - base_v), 32'd1);
        checkOutput("t3_data",        32'(bus_a.o_rx_data),      32'h0F);

        $display("[TB] test 4: MSB-first, two stop bits");
        base_v = valid_cnt_b; base_e = err_cnt_b;
        // 0x48 sent LSB-first puts 0,0,0,1,0,0,1,0 on the line
        sendFrame(1, 8'h48, 1'b1, 1'b1, 2, BIT);
        waitClk(100);
        checkOutput("t4_valid_count", 32'(valid_cnt_b - base_v), 32'd1);
        checkOutput("t4_data",        32'(bus_b.o_rx_data),      32'h12);
        checkOutput("t4_no_err",      32'(err_cnt_b - base_e),   32'd0);
        sendFrame(1, 8'h48, 1'b1, 1'b0, 2, BIT);
        applyStimulus(1, 1'b1, BIT);
        checkOutput("t4_err_count",   32'(err_cnt_b - base_e),   32'd1);
        checkOutput("t4_valid_held",  32'(valid_cnt_b - base_v), 32'd1);
        checkOutput("t4_data_held",   32'(bus_b.o_rx_data),      32'h12);

        $display("[TB] test 5: reset mid-frame then 0x81");
        base_v = valid_cnt_a;
        applyStimulus(0, 1'b0, BIT);
        applyStimulus(0, 1'b0, 4 * BIT);
        applyStimulus(0, 1'b1, 80);
        rst = 1'b1;
        waitClk(1);
        checkOutput("t5_rst_data",  32'(bus_a.o_rx_data),   32'h00);
        checkOutput("t5_rst_valid", 32'(bus_a.o_rx_valid),  32'h0);
        checkOutput("t5_rst_err",   32'(bus_a.o_frame_err), 32'h0);
        checkOutput("t5_rst_busy",  32'(bus_a.o_busy),      32'h0);
        rst = 1'b0;
        applyStimulus(0, 1'b1, 79 + 4 * BIT + 200);
        checkOutput("t5_aborted_no_valid", 32'(valid_cnt_a - base_v), 32'd0);
        sendFrame(0, 8'h81, 1'b1, 1'b1, 1, BIT);
        waitClk(100);
        checkOutput("t5_valid_count", 32'(valid_cnt_a - base_v), 32'd1);
        checkOutput("t5_data",        32'(bus_a.o_rx_data),      32'h81);

        $display("[TB] test 6: back-to-back skewed frames");
        waitClk(200);
        base_v = valid_cnt_a; base_e = err_cnt_a;
        sendFrame(0, 8'h00, 1'b1, 1'b1, 1, 165);
        sendFrame(0, 8'hFF, 1'b1, 1'b1, 1, 155);
        waitClk(200);
        checkOutput("t6_valid_count", 32'(valid_cnt_a - base_v), 32'd2);
        checkOutput("t6_err_count",   32'(err_cnt_a - base_e),   32'd0);
        checkOutput("t6_first_data",  32'(prev_data_a),          32'h00);
        checkOutput("t6_second_data", 32'(bus_a.o_rx_data),      32'hFF);

        checkOutput("strobe_rules_a", 32'(bad_a), 32'd0);
        checkOutput("strobe_rules_b", 32'(bad_b), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
